sprite_tx: RTL and testbench

Serial transmitter for the three-wire sprite command link (`spr_clk`, `spr_cmd`, `spr_ser`). It is the sending end of the link whose receiver latches a 4-bit command and a 10-bit data word and issues a one-cycle write strobe. The block accepts one {command, data} word per valid/ready handshake and serialises it as 4 command bits, then 10 data bits, then one strobe bit. It sits on the host/controller side, driving the link from an internal register interface.

---
 rtl/sprite_tx_if.sv | 23 ++
 rtl/sprite_tx.sv | 117 +++++++++++
 tb/tb_sprite_tx.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_tx_if.sv
// Host-side frame handshake for the sprite link transmitter.
interface sprite_tx_if;
    logic       in_valid;
    logic [3:0] in_command;
    logic [9:0] in_data;
    logic       in_ready;

    // Host offers frames and observes readiness.
    modport master (
        output in_valid,
        output in_command,
        output in_data,
        input  in_ready
    );

    // Transmitter accepts frames and reports readiness.
    modport slave (
        input  in_valid,
        input  in_command,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/sprite_tx.sv
// Sprite link transmitter: serialises {cmd[3:0], data[9:0]} MSB first on
// spr_ser, clocked by spr_clk, then sends one strobe bit with spr_cmd=1.
module sprite_tx #(
    parameter int unsigned HALF = 4
) (
    input  logic        clk,
    input  logic        reset,
    sprite_tx_if.slave  host,
    output logic        busy,
    output logic        done,
    output logic        spr_clk,
    output logic        spr_cmd,
    output logic        spr_ser
);

    localparam int unsigned FRAME_BITS = 14;
    localparam int unsigned CNT_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] HALF_M1    = CNT_W'(HALF - 1);
    localparam logic [3:0]       STROBE_IDX = 4'(FRAME_BITS);
    localparam logic [3:0]       LAST_DATA  = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [3:0]              bit_idx;
    logic [CNT_W-1:0]        half_cnt;

    // Frame sequencer: every link output is a register updated here. The
    // shift register rotates so no bit is left dangling; only bits ahead of
    // the current index are ever put on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_idx        <= '0;
            half_cnt       <= '0;
            host.in_ready  <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            spr_clk        <= 1'b0;
            spr_cmd        <= 1'b0;
            spr_ser        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.in_valid) begin
                        shreg         <= {host.in_command, host.in_data};
                        bit_idx       <= '0;
                        half_cnt      <= HALF_M1;
                        spr_clk       <= 1'b0;
                        spr_cmd       <= 1'b0;
                        spr_ser       <= host.in_command[3];
                        host.in_ready <= 1'b0;
                        busy          <= 1'b1;
                        state         <= LOW;
                    end
                end

                LOW: begin
                    if (half_cnt == '0) begin
                        half_cnt <= HALF_M1;
                        spr_clk  <= 1'b1;
                        state    <= HIGH;
                    end else begin
                        half_cnt <= half_cnt - CNT_W'(1);
                    end
                end

                HIGH: begin
                    if (half_cnt == '0) begin
                        half_cnt <= HALF_M1;
                        spr_clk  <= 1'b0;
                        if (bit_idx < STROBE_IDX) begin
                            // Falling edge: present the next bit or the strobe.
                            bit_idx <= bit_idx + 4'd1;
                            shreg   <= {shreg[FRAME_BITS-2:0], shreg[FRAME_BITS-1]};
                            if (bit_idx == LAST_DATA) begin
                                spr_cmd <= 1'b1;
                                spr_ser <= 1'b0;
                            end else begin
                                spr_cmd <= 1'b0;
                                spr_ser <= shreg[FRAME_BITS-2];
                            end
                            state <= LOW;
                        end else begin
                            // Strobe high phase over: frame complete.
                            spr_cmd       <= 1'b0;
                            spr_ser       <= 1'b0;
                            host.in_ready <= 1'b1;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= IDLE;
                        end
                    end else begin
                        half_cnt <= half_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state         <= IDLE;
                    host.in_ready <= 1'b1;
                    busy          <= 1'b0;
                    spr_clk       <= 1'b0;
                    spr_cmd       <= 1'b0;
                    spr_ser       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_tx.sv
// Bench for sprite_tx: two instances (HALF=4 and HALF=2), a link receiver
// model per lane and a scoreboard of accepted frames.
module tb_sprite_tx;

    localparam int unsigned HALF_A = 4;
    localparam int unsigned HALF_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       v   [2];
    logic [3:0] c   [2];
    logic [9:0] d   [2];

    sprite_tx_if ifa ();
    sprite_tx_if ifb ();

    assign ifa.in_valid   = v[0];
    assign ifa.in_command = c[0];
    assign ifa.in_data    = d[0];
    assign ifb.in_valid   = v[1];
    assign ifb.in_command = c[1];
    assign ifb.in_data    = d[1];

    logic busy_a, done_a, sclk_a, scmd_a, sser_a;
    logic busy_b, done_b, sclk_b, scmd_b, sser_b;

    sprite_tx #(.HALF(HALF_A)) dut_a (
        .clk(clk), .reset(rst[0]), .host(ifa.slave),
        .busy(busy_a), .done(done_a),
        .spr_clk(sclk_a), .spr_cmd(scmd_a), .spr_ser(sser_a)
    );

    sprite_tx #(.HALF(HALF_B)) dut_b (
        .clk(clk), .reset(rst[1]), .host(ifb.slave),
        .busy(busy_b), .done(done_b),
        .spr_clk(sclk_b), .spr_cmd(scmd_b), .spr_ser(sser_b)
    );

    // Status word per lane: {ready, busy, done, spr_clk, spr_cmd, spr_ser}
    logic [5:0] st [2];
    assign st[0] = {ifa.in_ready, busy_a, done_a, sclk_a, scmd_a, sser_a};
    assign st[1] = {ifb.in_ready, busy_b, done_b, sclk_b, scmd_b, sser_b};

    int unsigned half_of [2];
    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q  [2][$];
    logic [1:0]  wire_q [2][$];
    logic [13:0] rx_sr  [2];
    logic [13:0] last_rx[2];
    logic [5:0]  prev   [2];
    int          hi_run [2];
    int          acc_cnt[2];
    int          acc_cyc[2];
    int          wr_cnt [2];
    int          done_cnt[2];
    int          last_lat[2];
    int          cyc = 0;
    logic [5:0]  ms;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: receiver model, scoreboard, per-cycle link invariants.
    always @(negedge clk) begin
        cyc++;
        for (int l = 0; l < 2; l++) begin
            ms = st[l];
            if (rst[l]) begin
                exp_q[l].delete();
                hi_run[l] = 0;
                prev[l]   = ms;
            end else begin
                chk("ready_vs_busy", 32'(ms[5] ^ ms[4]), 32'd1);
                if (!ms[4]) chk("idle_lines", 32'(ms[2:0]), 32'd0);
                if (v[l] && ms[5]) begin
                    exp_q[l].push_back({c[l], d[l]});
                    acc_cnt[l]++;
                    acc_cyc[l] = cyc;
                end
                if (ms[3]) begin
                    done_cnt[l]++;
                    last_lat[l] = cyc - acc_cyc[l] - 1;
                end
                if (prev[l][2] && ms[2])
                    chk("stable_while_high", 32'(ms[1:0]), 32'(prev[l][1:0]));
                if (ms[2]) hi_run[l]++;
                if (prev[l][2] && !ms[2]) begin
                    chk("clk_high_len", 32'(hi_run[l]), 32'(half_of[l]));
                    hi_run[l] = 0;
                end
                if (ms[2] && !prev[l][2]) begin
                    wire_q[l].push_back(ms[1:0]);
                    if (ms[1]) begin
                        wr_cnt[l]++;
                        last_rx[l] = rx_sr[l];
                        if (exp_q[l].size() == 0) begin
                            chk("unexpected_write", 32'd1, 32'd0);
                        end else begin
                            chk("rx_decode", 32'(rx_sr[l]), 32'(exp_q[l].pop_front()));
                        end
                    end else begin
                        rx_sr[l] = {rx_sr[l][12:0], ms[0]};
                    end
                end
                prev[l] = ms;
            end
        end
    end

    task automatic start(input int l, input logic [3:0] cm, input logic [9:0] dt);
        bit ok;
        ok = 0;
        wire_q[l].delete();
        @(posedge clk); #1;
        v[l] = 1'b1; c[l] = cm; d[l] = dt;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            if (st[l][5]) ok = 1;
        end
        if (!ok) chk("start_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        v[l] = 1'b0;
        @(negedge clk);
        chk("t1_state", 32'(st[l]), 32'({5'b01000, cm[3]}));
    endtask

    task automatic wait_done(input int l);
        bit ok;
        ok = 0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            if (st[l][3]) ok = 1;
        end
        if (!ok) chk("done_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_acc(input int l, input int target);
        bit ok;
        ok = 0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            if (acc_cnt[l] >= target) ok = 1;
        end
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_wire(input int l, input logic [13:0] wexp);
        logic [13:0] sb;
        logic [13:0] cb;
        sb = '0;
        cb = '0;
        chk("wire_len", 32'(wire_q[l].size()), 32'd15);
        if (wire_q[l].size() == 15) begin
            for (int k = 0; k < 14; k++) begin
                sb[13-k] = wire_q[l][k][0];
                cb[13-k] = wire_q[l][k][1];
            end
            chk("wire_bits", 32'(sb), 32'(wexp));
            chk("wire_cmd_low", 32'(cb), 32'd0);
            chk("strobe_bit", 32'(wire_q[l][14]), 32'd2);
        end
    endtask

    typedef struct {
        int          lane;
        logic [3:0]  cm;
        logic [9:0]  dt;
        logic [13:0] wexp;
        int          lat;
    } vec_t;

    vec_t tbl [5];
    int   ln, wr0, dn0, acc0, a1;
    bit   seen;

    initial begin
        half_of[0] = HALF_A;
        half_of[1] = HALF_B;
        for (int l = 0; l < 2; l++) begin
            rst[l] = 1'b1; v[l] = 1'b0; c[l] = '0; d[l] = '0;
            rx_sr[l] = '0; last_rx[l] = '0; prev[l] = '0; hi_run[l] = 0;
            acc_cnt[l] = 0; acc_cyc[l] = 0; wr_cnt[l] = 0; done_cnt[l] = 0; last_lat[l] = 0;
        end

        tbl[0] = '{0, 4'hA, 10'h2C5, 14'b1010_1011000101, 120};
        tbl[1] = '{0, 4'h3, 10'h3FF, 14'b0011_1111111111, 120};
        tbl[2] = '{0, 4'hC, 10'h000, 14'b1100_0000000000, 120};
        tbl[3] = '{0, 4'h6, 10'h1B3, 14'b0110_0110110011, 120};
        tbl[4] = '{1, 4'hF, 10'h001, 14'b1111_0000000001, 60};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state_a", 32'(st[0]), 32'h20);
        chk("reset_state_b", 32'(st[1]), 32'h20);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single frames from the table
        for (int i = 0; i < 5; i++) begin
            ln  = tbl[i].lane;
            wr0 = wr_cnt[ln];
            dn0 = done_cnt[ln];
            start(ln, tbl[i].cm, tbl[i].dt);
            wait_done(ln);
            chk("latency", 32'(last_lat[ln]), 32'(tbl[i].lat));
            chk("write_count", 32'(wr_cnt[ln] - wr0), 32'd1);
            chk("done_count", 32'(done_cnt[ln] - dn0), 32'd1);
            chk("rx_word", 32'(last_rx[ln]), 32'({tbl[i].cm, tbl[i].dt}));
            chk("sb_drained", 32'(exp_q[ln].size()), 32'd0);
            chk_wire(ln, tbl[i].wexp);
        end

        // Back-to-back frames with in_valid held high
        acc0 = acc_cnt[0];
        wr0  = wr_cnt[0];
        @(posedge clk); #1;
        v[0] = 1'b1; c[0] = 4'h3; d[0] = 10'h3FF;
        wait_acc(0, acc0 + 1);
        a1 = acc_cyc[0];
        @(posedge clk); #1;
        c[0] = 4'hC; d[0] = 10'h000;
        wait_acc(0, acc0 + 2);
        chk("b2b_gap", 32'(acc_cyc[0] - a1), 32'(30 * HALF_A + 1));
        @(posedge clk); #1;
        v[0] = 1'b0;
        wait_done(0);
        chk("b2b_writes", 32'(wr_cnt[0] - wr0), 32'd2);
        chk("b2b_last_rx", 32'(last_rx[0]), 32'({4'hC, 10'h000}));
        chk("b2b_sb_drained", 32'(exp_q[0].size()), 32'd0);

        // Inputs churn while a frame is in flight
        acc0 = acc_cnt[0];
        wr0  = wr_cnt[0];
        wire_q[0].delete();
        @(posedge clk); #1;
        v[0] = 1'b1; c[0] = 4'h1; d[0] = 10'h155;
        wait_acc(0, acc0 + 1);
        seen = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(posedge clk); #1;
            if (st[0][3]) begin
                seen = 1;
                v[0] = 1'b0;
            end else begin
                c[0] = 4'($urandom);
                d[0] = 10'($urandom);
            end
        end
        if (!seen) chk("churn_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        chk("churn_accepts", 32'(acc_cnt[0] - acc0), 32'd1);
        chk("churn_writes", 32'(wr_cnt[0] - wr0), 32'd1);
        chk("churn_rx", 32'(last_rx[0]), 32'({4'h1, 10'h155}));
        chk_wire(0, 14'b0001_0101010101);

        // Reset in the low phase of bit 7, then a clean frame
        wr0 = wr_cnt[0];
        dn0 = done_cnt[0];
        start(0, 4'h5, 10'h0AA);
        repeat (57) @(posedge clk);
        #1;
        chk("pre_reset_low", 32'(st[0][4:2]), 32'd4);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("reset_abort", 32'(st[0]), 32'h20);
        chk("abort_no_done", 32'(done_cnt[0] - dn0), 32'd0);
        chk("abort_no_write", 32'(wr_cnt[0] - wr0), 32'd0);
        start(0, 4'h6, 10'h1B3);
        wait_done(0);
        chk("post_reset_latency", 32'(last_lat[0]), 32'(30 * HALF_A));
        chk("post_reset_rx", 32'(last_rx[0]), 32'({4'h6, 10'h1B3}));
        chk_wire(0, 14'b0110_0110110011);

        // Long idle: no activity, no done
        dn0 = done_cnt[0];
        a1  = done_cnt[1];
        repeat (500) @(negedge clk);
        chk("idle_done_a", 32'(done_cnt[0] - dn0), 32'd0);
        chk("idle_done_b", 32'(done_cnt[1] - a1), 32'd0);
        chk("idle_state_a", 32'(st[0]), 32'h20);
        chk("idle_state_b", 32'(st[1]), 32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
